// File: rtl/sms_ahb_bank_dec.sv
// AHB-Lite decoder and response mux in front of the four SMS banks; local two-cycle ERROR for bad accesses.
// Optional macro SMS_DEC_PRIV_CHK_EN: user-mode accesses to banks flagged in PROT_BANK_MASK are rejected.
//
// state | meaning
// IDLE  | no data phase outstanding, zero-wait OKAY
// BANK  | data phase owned by bank dsel, its response is muxed upstream
// ERR1  | first ERROR cycle (hready low)
// ERR2  | second ERROR cycle (hready high), may accept the next address phase
module sms_ahb_bank_dec #(
   parameter logic [31:0] BASE_ADDR      = 32'h2000_0000,
   parameter int          BANK_AW        = 16,
   parameter logic [3:0]  PROT_BANK_MASK = 4'b0000
) (
   input  logic        pmu_sms_hclk,
   input  logic        pmu_sms_hrst_b,
   input  logic        ahb_sms_hsel,
   input  logic [1:0]  ahb_sms_htrans,
   input  logic [31:0] ahb_sms_haddr,
   input  logic [2:0]  ahb_sms_hsize,
   input  logic [3:0]  ahb_sms_hprot,
   input  logic        ahb_sms_hwrite,
   input  logic [31:0] ahb_sms_hwdata,
   input  logic        ahb_sms_hready,
   output logic [31:0] sms_ahb_hrdata,
   output logic        sms_ahb_hready,
   output logic [1:0]  sms_ahb_hresp,
   output logic        ahb_sms0_hsel,
   output logic [1:0]  ahb_sms0_htrans,
   output logic [31:0] ahb_sms0_haddr,
   output logic [2:0]  ahb_sms0_hsize,
   output logic [3:0]  ahb_sms0_hprot,
   output logic        ahb_sms0_hwrite,
   output logic [31:0] ahb_sms0_hwdata,
   output logic        ahb_sms1_hsel,
   output logic [1:0]  ahb_sms1_htrans,
   output logic [31:0] ahb_sms1_haddr,
   output logic [2:0]  ahb_sms1_hsize,
   output logic [3:0]  ahb_sms1_hprot,
   output logic        ahb_sms1_hwrite,
   output logic [31:0] ahb_sms1_hwdata,
   output logic        ahb_sms2_hsel,
   output logic [1:0]  ahb_sms2_htrans,
   output logic [31:0] ahb_sms2_haddr,
   output logic [2:0]  ahb_sms2_hsize,
   output logic [3:0]  ahb_sms2_hprot,
   output logic        ahb_sms2_hwrite,
   output logic [31:0] ahb_sms2_hwdata,
   output logic        ahb_sms3_hsel,
   output logic [1:0]  ahb_sms3_htrans,
   output logic [31:0] ahb_sms3_haddr,
   output logic [2:0]  ahb_sms3_hsize,
   output logic [3:0]  ahb_sms3_hprot,
   output logic        ahb_sms3_hwrite,
   output logic [31:0] ahb_sms3_hwdata,
   input  logic [31:0] sms0_ahb_hrdata,
   input  logic        sms0_ahb_hready,
   input  logic [1:0]  sms0_ahb_hresp,
   input  logic [31:0] sms1_ahb_hrdata,
   input  logic        sms1_ahb_hready,
   input  logic [1:0]  sms1_ahb_hresp,
   input  logic [31:0] sms2_ahb_hrdata,
   input  logic        sms2_ahb_hready,
   input  logic [1:0]  sms2_ahb_hresp,
   input  logic [31:0] sms3_ahb_hrdata,
   input  logic        sms3_ahb_hready,
   input  logic [1:0]  sms3_ahb_hresp,
   input  logic        sms0_idle,
   input  logic        sms1_idle,
   input  logic        sms2_idle,
   input  logic        sms3_idle,
   output logic        sms_idle
);

   typedef enum logic [1:0] {ST_IDLE, ST_BANK, ST_ERR1, ST_ERR2} state_t;

   state_t      state, state_nxt, decode_nxt;
   logic [1:0]  dsel, dsel_nxt, bank;
   logic        accept, win_miss, size_err, priv_err, err_req, bank_go;
   logic [31:0] bank_hrdata;
   logic        bank_hready;
   logic [1:0]  bank_hresp;

   assign bank     = ahb_sms_haddr[BANK_AW+1:BANK_AW];
   assign accept   = ahb_sms_hsel & ahb_sms_htrans[1] & ahb_sms_hready & sms_ahb_hready;
   assign win_miss = ahb_sms_haddr[31:BANK_AW+2] != BASE_ADDR[31:BANK_AW+2];
   assign size_err = ahb_sms_hsize > 3'b010;

`ifdef SMS_DEC_PRIV_CHK_EN
   assign priv_err = ~ahb_sms_hprot[1] & PROT_BANK_MASK[bank];
`else
   // Mask forced to zero so the privilege term folds away; hprot is only forwarded.
   localparam logic [3:0] PRIV_MASK_OFF = PROT_BANK_MASK & 4'b0000;
   assign priv_err = ~ahb_sms_hprot[1] & PRIV_MASK_OFF[bank];
`endif

   assign err_req = accept & (win_miss | size_err | priv_err);
   assign bank_go = accept & ~err_req;

   assign ahb_sms0_hsel = bank_go & (bank == 2'd0);
   assign ahb_sms1_hsel = bank_go & (bank == 2'd1);
   assign ahb_sms2_hsel = bank_go & (bank == 2'd2);
   assign ahb_sms3_hsel = bank_go & (bank == 2'd3);

   assign ahb_sms0_htrans = ahb_sms_htrans;
   assign ahb_sms1_htrans = ahb_sms_htrans;
   assign ahb_sms2_htrans = ahb_sms_htrans;
   assign ahb_sms3_htrans = ahb_sms_htrans;
   assign ahb_sms0_haddr  = ahb_sms_haddr;
   assign ahb_sms1_haddr  = ahb_sms_haddr;
   assign ahb_sms2_haddr  = ahb_sms_haddr;
   assign ahb_sms3_haddr  = ahb_sms_haddr;
   assign ahb_sms0_hsize  = ahb_sms_hsize;
   assign ahb_sms1_hsize  = ahb_sms_hsize;
   assign ahb_sms2_hsize  = ahb_sms_hsize;
   assign ahb_sms3_hsize  = ahb_sms_hsize;
   assign ahb_sms0_hprot  = ahb_sms_hprot;
   assign ahb_sms1_hprot  = ahb_sms_hprot;
   assign ahb_sms2_hprot  = ahb_sms_hprot;
   assign ahb_sms3_hprot  = ahb_sms_hprot;
   assign ahb_sms0_hwrite = ahb_sms_hwrite;
   assign ahb_sms1_hwrite = ahb_sms_hwrite;
   assign ahb_sms2_hwrite = ahb_sms_hwrite;
   assign ahb_sms3_hwrite = ahb_sms_hwrite;
   assign ahb_sms0_hwdata = ahb_sms_hwdata;
   assign ahb_sms1_hwdata = ahb_sms_hwdata;
   assign ahb_sms2_hwdata = ahb_sms_hwdata;
   assign ahb_sms3_hwdata = ahb_sms_hwdata;

   always_comb begin
      bank_hrdata = sms0_ahb_hrdata;
      bank_hready = sms0_ahb_hready;
      bank_hresp  = sms0_ahb_hresp;
      case (dsel)
         2'd1: begin
            bank_hrdata = sms1_ahb_hrdata;
            bank_hready = sms1_ahb_hready;
            bank_hresp  = sms1_ahb_hresp;
         end
         2'd2: begin
            bank_hrdata = sms2_ahb_hrdata;
            bank_hready = sms2_ahb_hready;
            bank_hresp  = sms2_ahb_hresp;
         end
         2'd3: begin
            bank_hrdata = sms3_ahb_hrdata;
            bank_hready = sms3_ahb_hready;
            bank_hresp  = sms3_ahb_hresp;
         end
         default: ;
      endcase
   end

   always_ff @(posedge pmu_sms_hclk or negedge pmu_sms_hrst_b) begin
      if (!pmu_sms_hrst_b) begin
         state <= ST_IDLE;
         dsel  <= 2'b00;
      end else begin
         state <= state_nxt;
         dsel  <= dsel_nxt;
      end
   end

   always_comb begin
      sms_ahb_hready = 1'b1;
      sms_ahb_hresp  = 2'b00;
      sms_ahb_hrdata = 32'h0;
      state_nxt      = state;
      dsel_nxt       = dsel;
      decode_nxt     = err_req ? ST_ERR1 : (bank_go ? ST_BANK : ST_IDLE);
      if (bank_go) dsel_nxt = bank;
      case (state)
         ST_IDLE: state_nxt = decode_nxt;
         ST_BANK: begin
            sms_ahb_hready = bank_hready;
            sms_ahb_hresp  = bank_hresp;
            sms_ahb_hrdata = bank_hrdata;
            if (bank_hready) state_nxt = decode_nxt;
         end
         ST_ERR1: begin
            sms_ahb_hready = 1'b0;
            sms_ahb_hresp  = 2'b01;
            state_nxt      = ST_ERR2;
         end
         ST_ERR2: begin
            sms_ahb_hresp = 2'b01;
            state_nxt     = decode_nxt;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign sms_idle = sms0_idle & sms1_idle & sms2_idle & sms3_idle & (state == ST_IDLE) & ~accept;

endmodule

// File: tb/tb_sms_ahb_bank_dec.sv
// Scoreboard bench for sms_ahb_bank_dec with four behavioural SMS bank models.
module tb_sms_ahb_bank_dec;

   logic        clk, rst_n;
   logic        hsel, hwrite;
   logic [1:0]  htrans;
   logic [31:0] haddr, hwdata;
   logic [2:0]  hsize;
   logic [3:0]  hprot;
   logic        bus_hready;
   logic [31:0] up_hrdata;
   logic        up_hready;
   logic [1:0]  up_hresp;
   logic        sms_idle;
   logic [3:0]  idle_in;

   logic [3:0]  b_hsel;
   logic [1:0]  b_htrans [4];
   logic [31:0] b_haddr  [4];
   logic [2:0]  b_hsize  [4];
   logic [3:0]  b_hprot  [4];
   logic        b_hwrite [4];
   logic [31:0] b_hwdata [4];
   logic [31:0] b_rdata  [4];
   logic        b_rdy    [4];
   logic [1:0]  b_resp   [4];

   logic        b_dp  [4];
   logic        b_wr  [4];
   logic [3:0]  b_idx [4];
   int          b_wcnt [4];
   logic [31:0] mem [4][16];
   int          cfg_waits [4];
   bit          cfg_err [4];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]  sel;
      int          waits;
      logic [1:0]  resp;
      logic [1:0]  stall_resp;
      logic [31:0] rdata;
      bit          chk_rd;
   } exp_t;
   exp_t sb_q[$];

   assign bus_hready = up_hready;

   sms_ahb_bank_dec #(.BASE_ADDR(32'h2000_0000), .BANK_AW(16), .PROT_BANK_MASK(4'b0100)) dut (
      .pmu_sms_hclk(clk), .pmu_sms_hrst_b(rst_n),
      .ahb_sms_hsel(hsel), .ahb_sms_htrans(htrans), .ahb_sms_haddr(haddr), .ahb_sms_hsize(hsize),
      .ahb_sms_hprot(hprot), .ahb_sms_hwrite(hwrite), .ahb_sms_hwdata(hwdata), .ahb_sms_hready(bus_hready),
      .sms_ahb_hrdata(up_hrdata), .sms_ahb_hready(up_hready), .sms_ahb_hresp(up_hresp),
      .ahb_sms0_hsel(b_hsel[0]), .ahb_sms0_htrans(b_htrans[0]), .ahb_sms0_haddr(b_haddr[0]),
      .ahb_sms0_hsize(b_hsize[0]), .ahb_sms0_hprot(b_hprot[0]), .ahb_sms0_hwrite(b_hwrite[0]),
      .ahb_sms0_hwdata(b_hwdata[0]),
      .ahb_sms1_hsel(b_hsel[1]), .ahb_sms1_htrans(b_htrans[1]), .ahb_sms1_haddr(b_haddr[1]),
      .ahb_sms1_hsize(b_hsize[1]), .ahb_sms1_hprot(b_hprot[1]), .ahb_sms1_hwrite(b_hwrite[1]),
      .ahb_sms1_hwdata(b_hwdata[1]),
      .ahb_sms2_hsel(b_hsel[2]), .ahb_sms2_htrans(b_htrans[2]), .ahb_sms2_haddr(b_haddr[2]),
      .ahb_sms2_hsize(b_hsize[2]), .ahb_sms2_hprot(b_hprot[2]), .ahb_sms2_hwrite(b_hwrite[2]),
      .ahb_sms2_hwdata(b_hwdata[2]),
      .ahb_sms3_hsel(b_hsel[3]), .ahb_sms3_htrans(b_htrans[3]), .ahb_sms3_haddr(b_haddr[3]),
      .ahb_sms3_hsize(b_hsize[3]), .ahb_sms3_hprot(b_hprot[3]), .ahb_sms3_hwrite(b_hwrite[3]),
      .ahb_sms3_hwdata(b_hwdata[3]),
      .sms0_ahb_hrdata(b_rdata[0]), .sms0_ahb_hready(b_rdy[0]), .sms0_ahb_hresp(b_resp[0]),
      .sms1_ahb_hrdata(b_rdata[1]), .sms1_ahb_hready(b_rdy[1]), .sms1_ahb_hresp(b_resp[1]),
      .sms2_ahb_hrdata(b_rdata[2]), .sms2_ahb_hready(b_rdy[2]), .sms2_ahb_hresp(b_resp[2]),
      .sms3_ahb_hrdata(b_rdata[3]), .sms3_ahb_hready(b_rdy[3]), .sms3_ahb_hresp(b_resp[3]),
      .sms0_idle(idle_in[0]), .sms1_idle(idle_in[1]), .sms2_idle(idle_in[2]), .sms3_idle(idle_in[3]),
      .sms_idle(sms_idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Bank model: programmable wait states and optional ERROR on the final two cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 4; n++) begin
            b_dp[n]   <= 1'b0;
            b_wr[n]   <= 1'b0;
            b_idx[n]  <= 4'h0;
            b_wcnt[n] <= 0;
            for (int i = 0; i < 16; i++) mem[n][i] <= ((n + 1) << 24) + i;
         end
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (b_dp[n] && b_rdy[n] && b_wr[n]) mem[n][b_idx[n]] <= b_hwdata[n];
            if (b_hsel[n]) begin
               b_dp[n]   <= 1'b1;
               b_wr[n]   <= b_hwrite[n];
               b_idx[n]  <= b_haddr[n][5:2];
               b_wcnt[n] <= 0;
            end else if (b_dp[n] && b_rdy[n]) begin
               b_dp[n] <= 1'b0;
            end else if (b_dp[n]) begin
               b_wcnt[n] <= b_wcnt[n] + 1;
            end
         end
      end
   end

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         b_rdy[n]   = !b_dp[n] || (b_wcnt[n] >= cfg_waits[n]);
         b_resp[n]  = (b_dp[n] && cfg_err[n] && (b_wcnt[n] + 1 >= cfg_waits[n])) ? 2'b01 : 2'b00;
         b_rdata[n] = (b_dp[n] && !b_wr[n]) ? mem[n][b_idx[n]] : 32'h0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: tracks address/data phases from the bus and pops the scoreboard on completion.
   initial begin
      bit         pend;
      int         mwaits;
      logic [1:0] mstall;
      logic [3:0] msel;
      exp_t       e;
      pend = 0; mwaits = 0; mstall = 2'b00; msel = 4'h0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend = 0;
            sb_q.delete();
         end else begin
            if (pend) begin
               if (up_hready) begin
                  if (sb_q.size() == 0) begin
                     chk("sb_underflow", 64'd1, 64'd0);
                  end else begin
                     e = sb_q.pop_front();
                     chk("sel", {60'd0, msel}, {60'd0, e.sel});
                     chk("waits", 64'(mwaits), 64'(e.waits));
                     chk("resp", {62'd0, up_hresp}, {62'd0, e.resp});
                     if (e.chk_rd) chk("rdata", {32'd0, up_hrdata}, {32'd0, e.rdata});
                     if (e.waits > 0) chk("stall_resp", {62'd0, mstall}, {62'd0, e.stall_resp});
                  end
                  pend = 0;
               end else begin
                  mwaits++;
                  mstall = up_hresp;
               end
            end
            if (hsel && htrans[1] && up_hready) begin
               pend = 1; mwaits = 0; msel = b_hsel;
               for (int n = 0; n < 4; n++)
                  chk("bcast", {23'd0, b_htrans[n], b_hsize[n], b_hprot[n], b_hwrite[n], b_haddr[n]},
                      {23'd0, htrans, hsize, hprot, hwrite, haddr});
            end else begin
               chk("no_hsel", {60'd0, b_hsel}, 64'd0);
            end
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [3:0] pr,
                        input logic [31:0] wd, input logic [3:0] esel, input int ewaits,
                        input logic [1:0] eresp, input logic [1:0] estall, input logic [31:0] erd,
                        input bit chkrd);
      exp_t e;
      int   n;
      bit   acc;
      hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz; hprot = pr;
      e.sel = esel; e.waits = ewaits; e.resp = eresp; e.stall_resp = estall; e.rdata = erd; e.chk_rd = chkrd;
      sb_q.push_back(e);
      n = 0; acc = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = up_hready;
         @(posedge clk); #1;
         n++;
      end
      if (!acc) chk("accept_timeout", 64'd0, 64'd1);
      hwdata = wd;
   endtask

   task automatic idle_bus(input int k);
      hsel = 1'b0; htrans = 2'b00;
      repeat (k) begin @(posedge clk); #1; end
   endtask

   initial begin
      for (int n = 0; n < 4; n++) begin cfg_waits[n] = 0; cfg_err[n] = 0; end
      rst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0;
      hsize = 3'b010; hprot = 4'b0011; hwdata = 32'h0; idle_in = 4'hF;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset / idle state
      @(negedge clk);
      chk("rst_hready", {63'd0, up_hready}, 64'd1);
      chk("rst_hresp", {62'd0, up_hresp}, 64'd0);
      chk("rst_hrdata", {32'd0, up_hrdata}, 64'd0);
      chk("rst_hsel", {60'd0, b_hsel}, 64'd0);
      chk("rst_sms_idle", {63'd0, sms_idle}, 64'd1);
      idle_in = 4'b1011; #1;
      chk("idle_bank2_busy", {63'd0, sms_idle}, 64'd0);
      idle_in = 4'hF;
      @(posedge clk); #1;

      // hsel with BUSY: zero-wait OKAY, no bank select
      hsel = 1'b1; htrans = 2'b01; haddr = 32'h2001_0000;
      @(negedge clk);
      chk("busy_hready", {63'd0, up_hready}, 64'd1);
      chk("busy_hresp", {62'd0, up_hresp}, 64'd0);
      @(posedge clk); #1;

      // Write then read back through bank 1
      issue(32'h2001_0004, 1'b1, 3'b010, 4'b0011, 32'hA5A5_0001, 4'b0010, 0, 2'b00, 2'b00, 32'h0, 0);
      issue(32'h2001_0004, 1'b0, 3'b010, 4'b0011, 32'h0, 4'b0010, 0, 2'b00, 2'b00, 32'hA5A5_0001, 1);
      chk("busy_sms_idle", {63'd0, sms_idle}, 64'd0);
      idle_bus(2);

      // Back-to-back reads to banks 0, 3, 2
      issue(32'h2000_0000, 1'b0, 3'b010, 4'b0011, 32'h0, 4'b0001, 0, 2'b00, 2'b00, 32'h0100_0000, 1);
      issue(32'h2003_0000, 1'b0, 3'b010, 4'b0011, 32'h0, 4'b1000, 0, 2'b00, 2'b00, 32'h0400_0000, 1);
      issue(32'h2002_0000, 1'b0, 3'b010, 4'b0011, 32'h0, 4'b0100, 0, 2'b00, 2'b00, 32'h0300_0000, 1);
      idle_bus(2);

      // Out-of-window read, then a transfer accepted during ERR2
      issue(32'h2004_0000, 1'b0, 3'b010, 4'b0011, 32'h0, 4'b0000, 1, 2'b01, 2'b01, 32'h0, 0);
      issue(32'h2000_0010, 1'b0, 3'b010, 4'b0011, 32'h0, 4'b0001, 0, 2'b00, 2'b00, 32'h0100_0004, 1);
      idle_bus(2);

      // Oversize access, then bank-1 ERROR after two wait states
      issue(32'h2000_0000, 1'b0, 3'b011, 4'b0011, 32'h0, 4'b0000, 1, 2'b01, 2'b01, 32'h0, 0);
      idle_bus(1);
      cfg_waits[1] = 2; cfg_err[1] = 1;
      issue(32'h2001_0008, 1'b0, 3'b010, 4'b0011, 32'h0, 4'b0010, 2, 2'b01, 2'b01, 32'h0, 0);
      idle_bus(4);
      cfg_waits[1] = 0; cfg_err[1] = 0;

      // Privilege check on bank 2 (mask 4'b0100)
`ifdef SMS_DEC_PRIV_CHK_EN
      issue(32'h2002_0000, 1'b1, 3'b010, 4'b0001, 32'hDEAD_0001, 4'b0000, 1, 2'b01, 2'b01, 32'h0, 0);
`else
      issue(32'h2002_0000, 1'b1, 3'b010, 4'b0001, 32'hDEAD_0001, 4'b0100, 0, 2'b00, 2'b00, 32'h0, 0);
`endif
      issue(32'h2002_0000, 1'b1, 3'b010, 4'b0011, 32'hBEEF_0002, 4'b0100, 0, 2'b00, 2'b00, 32'h0, 0);
      issue(32'h2002_0000, 1'b0, 3'b010, 4'b0011, 32'h0, 4'b0100, 0, 2'b00, 2'b00, 32'hBEEF_0002, 1);
      idle_bus(3);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      // Reset during a stalled bank-3 data phase
      cfg_waits[3] = 3;
      issue(32'h2003_0004, 1'b0, 3'b010, 4'b0011, 32'h0, 4'b1000, 3, 2'b00, 2'b00, 32'h0400_0001, 1);
      hsel = 1'b0; htrans = 2'b00;
      @(negedge clk);
      chk("stall_hready", {63'd0, up_hready}, 64'd0);
      rst_n = 1'b0; #1;
      chk("midrst_hready", {63'd0, up_hready}, 64'd1);
      chk("midrst_hresp", {62'd0, up_hresp}, 64'd0);
      chk("midrst_hrdata", {32'd0, up_hrdata}, 64'd0);
      chk("midrst_hsel", {60'd0, b_hsel}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cfg_waits[3] = 0;
      idle_bus(2);
      @(negedge clk);
      chk("post_rst_sms_idle", {63'd0, sms_idle}, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
